// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int KP_COLS = 4;
  localparam int KP_ROWS = 4;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } kp_state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } frame_cls_t;

  typedef struct packed {
    frame_cls_t cls;
    logic [3:0] code;
  } frame_res_t;

  // Count the pressed keys in a frame map; the code is only meaningful
  // when exactly one key is down.
  function automatic frame_res_t classify(input logic [15:0] map);
    frame_res_t res;
    int         n;
    n        = 0;
    res.code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (map[i]) begin
        n        = n + 1;
        res.code = 4'(i);
      end
    end
    if (n == 0)      res.cls = NONE;
    else if (n == 1) res.cls = SINGLE;
    else             res.cls = MULTI;
    return res;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
  parameter int              WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;

  // Metastability filter: two back-to-back flops, reset to the idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_p0 <= RST_VAL;
      q       <= RST_VAL;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad column scanner with frame-based debounce.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       busy,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam int               CNT_W    = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       row_s;
  logic [DIV_W-1:0] div;
  logic [1:0]       col;
  logic [1:0]       col_nxt;
  logic [15:0]      map;
  logic [15:0]      map_cur;
  logic             sample;
  logic             frame_done;
  frame_res_t       res;

  kp_state_t        state, state_n;
  logic [3:0]       cand, cand_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]       code_n;
  logic             valid_n;
  logic             down_n;

  sync_2ff #(
    .WIDTH   (KP_ROWS),
    .RST_VAL ('1)
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_n),
    .q   (row_s)
  );

  assign sample     = (div == DIV_LAST) && !busy;
  assign frame_done = sample && (col == 2'd3);
  assign col_nxt    = col + 2'd1;
  assign cnt_inc    = (cnt >= CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;

  // Merge the current column's pressed rows into the frame map and classify.
  always_comb begin
    map_cur = map;
    for (int r = 0; r < KP_ROWS; r++) begin
      if (!row_s[r]) map_cur[{2'(r), col}] = 1'b1;
    end
    res = classify(map_cur);
  end

  // Dwell/column counters, column drive and frame map; busy restarts the scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div   <= '0;
      col   <= 2'd0;
      map   <= '0;
      col_n <= 4'b1110;
    end else if (busy) begin
      div   <= '0;
      col   <= 2'd0;
      map   <= '0;
      col_n <= 4'b1110;
    end else if (div == DIV_LAST) begin
      div   <= '0;
      col   <= col_nxt;
      col_n <= ~(4'b0001 << col_nxt);
      map   <= frame_done ? 16'd0 : map_cur;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Debounce state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= 4'd0;
      cnt       <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      key_down  <= down_n;
    end
  end

  // Debounce next-state: evaluated only on a completed, non-busy frame.
  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    code_n  = key_code;
    down_n  = key_down;
    valid_n = 1'b0;
    if (frame_done) begin
      case (state)
        IDLE: begin
          if (res.cls == SINGLE) begin
            cand_n = res.code;
            cnt_n  = CNT_ONE;
            if (DEBOUNCE_CNT == 1) begin
              state_n = HELD;
              code_n  = res.code;
              valid_n = 1'b1;
              down_n  = 1'b1;
            end else begin
              state_n = PRESS_CHK;
            end
          end
        end
        PRESS_CHK: begin
          if (res.cls == SINGLE && res.code == cand) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_n = HELD;
              code_n  = cand;
              valid_n = 1'b1;
              down_n  = 1'b1;
            end
          end else begin
            state_n = IDLE;
          end
        end
        HELD: begin
          if (res.cls == NONE) begin
            cnt_n = CNT_ONE;
            if (DEBOUNCE_CNT == 1) begin
              state_n = IDLE;
              down_n  = 1'b0;
            end else begin
              state_n = RELEASE_CHK;
            end
          end
        end
        RELEASE_CHK: begin
          if (res.cls == NONE) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_n = IDLE;
              down_n  = 1'b0;
            end
          end else begin
            state_n = HELD;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_CNT=3 (16-cycle frames).
module tb_keypad_scan;

  logic        clk;
  logic        rst;
  logic        busy;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] keys;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int pulses = 0;
  int p0;

  keypad_scan #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .busy      (busy),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Keypad matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_n = 4'hF;
    for (int k = 0; k < 16; k++) begin
      if (keys[k] && !col_n[k % 4]) row_n[k / 4] = 1'b0;
    end
  end

  // Count key_valid pulses (value of the cycle that just ended).
  always @(posedge clk) begin
    if (!rst && key_valid) pulses++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic go_to(input int t);
    while (cyc < t) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_col_n"},  16'(col_n),     16'hE);
    chk({tag, "_code"},   16'(key_code),  16'h0);
    chk({tag, "_valid"},  16'(key_valid), 16'h0);
    chk({tag, "_down"},   16'(key_down),  16'h0);
  endtask

  initial begin
    logic [3:0] exp_col;
    rst  = 1'b1;
    busy = 1'b0;
    keys = 16'h0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst_held");
    rst = 1'b0;
    cyc = 0;

    // Reset and scan: two full frames of column rotation, no pulses.
    for (int k = 0; k < 32; k++) begin
      go_to(k);
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      chk("scan_col_n", 16'(col_n), 16'(exp_col));
      if (k % 8 == 0) chk("scan_valid", 16'(key_valid), 16'h0);
    end

    // Clean press of key 0x9 (row 2, col 1) from frame start at cycle 32.
    go_to(32);
    p0   = pulses;
    keys = 16'h0200;
    go_to(79);
    chk("press_down_before", 16'(key_down), 16'h0);
    chk("press_valid_before", 16'(key_valid), 16'h0);
    go_to(80);
    chk("press_valid", 16'(key_valid), 16'h1);
    chk("press_code", 16'(key_code), 16'h9);
    chk("press_down", 16'(key_down), 16'h1);
    go_to(81);
    chk("press_valid_one_cycle", 16'(key_valid), 16'h0);
    go_to(112);
    chk("press_held_down", 16'(key_down), 16'h1);
    keys = 16'h0;
    go_to(159);
    chk("release_down_before", 16'(key_down), 16'h1);
    go_to(160);
    chk("release_down", 16'(key_down), 16'h0);
    go_to(176);
    chk("press_pulse_count", 16'(pulses - p0), 16'h1);

    // Bounce: 2 frames on, 1 off, 2 on, then off.
    p0   = pulses;
    keys = 16'h0200;
    go_to(208);
    keys = 16'h0;
    go_to(224);
    keys = 16'h0200;
    go_to(256);
    chk("bounce_down_mid", 16'(key_down), 16'h0);
    keys = 16'h0;
    go_to(288);
    chk("bounce_down", 16'(key_down), 16'h0);
    chk("bounce_pulses", 16'(pulses - p0), 16'h0);

    // Two keys together from IDLE.
    p0   = pulses;
    keys = 16'h0021;
    go_to(352);
    chk("multi_idle_pulses", 16'(pulses - p0), 16'h0);
    chk("multi_idle_down", 16'(key_down), 16'h0);

    // Key 0x9 held, then 0x3 added for 4 frames.
    keys = 16'h0200;
    go_to(400);
    chk("held_valid", 16'(key_valid), 16'h1);
    chk("held_code", 16'(key_code), 16'h9);
    keys = 16'h0208;
    go_to(464);
    chk("second_key_code", 16'(key_code), 16'h9);
    chk("second_key_down", 16'(key_down), 16'h1);
    chk("second_key_pulses", 16'(pulses - p0), 16'h1);
    keys = 16'h0;
    go_to(511);
    chk("second_release_before", 16'(key_down), 16'h1);
    go_to(512);
    chk("second_release_down", 16'(key_down), 16'h0);

    // busy for 10 cycles in the middle of column 2 while 0x9 is pressed.
    keys = 16'h0200;
    go_to(521);
    chk("busy_pre_col_n", 16'(col_n), 16'hB);
    busy = 1'b1;
    for (int k = 522; k <= 531; k++) begin
      go_to(k);
      chk("busy_col_n", 16'(col_n), 16'hE);
      if (k == 531) busy = 1'b0;
    end
    go_to(535);
    chk("busy_after_col_n", 16'(col_n), 16'hD);
    go_to(578);
    chk("busy_down_before", 16'(key_down), 16'h0);
    chk("busy_valid_before", 16'(key_valid), 16'h0);
    go_to(579);
    chk("busy_valid", 16'(key_valid), 16'h1);
    chk("busy_code", 16'(key_code), 16'h9);

    // Release, then rebuild a press to PRESS_CHK with cnt=2 and reset it.
    go_to(595);
    keys = 16'h0;
    go_to(643);
    chk("rstmid_idle_down", 16'(key_down), 16'h0);
    keys = 16'h0200;
    go_to(680);
    p0  = pulses;
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_async");
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    go_to(16);
    chk("rst_fresh_valid_early", 16'(key_valid), 16'h0);
    go_to(47);
    chk("rst_fresh_down_before", 16'(key_down), 16'h0);
    chk("rst_fresh_no_pulse", 16'(pulses - p0), 16'h0);
    go_to(48);
    chk("rst_fresh_valid", 16'(key_valid), 16'h1);
    chk("rst_fresh_code", 16'(key_code), 16'h9);
    chk("rst_fresh_down", 16'(key_down), 16'h1);
    go_to(50);
    chk("rst_fresh_pulses", 16'(pulses - p0), 16'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
